regfile_alu_sequencer: RTL and testbench

- Downstream consumer and driver of the 64x16 register file: accepts one register-to-register operation per request, reads two operands via AddressA/AddressB, computes an ALU result, writes it back through the shared AddressA/WriteData/WriteEnable port.
- Sole owner of the register file port set; sits between the instruction/control front end and the register file.

---
 rtl/regfile_seq_pkg.sv | 34 +++
 rtl/seq_alu.sv | 54 +++++
 rtl/regfile_alu_sequencer.sv | 146 ++++++++++++++
 tb/tb_regfile_alu_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_seq_pkg
// Brief    : Shared types and default widths for the register-file ALU
//            sequencer (opcodes, sequencer states, width defaults).
// Revision : 1.0 - initial release
// ============================================================================
package regfile_seq_pkg;

    localparam int c_DATA_WIDTH_DEFAULT = 16;
    localparam int c_ADDR_WIDTH_DEFAULT = 6;

    // 3-bit opcode carried on ReqOp
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_LDI = 3'b111
    } op_t;

    // One state per pipeline phase of an operation
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

endpackage : regfile_seq_pkg
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Brief    : Combinational ALU for the register-file sequencer. Produces the
//            result and carry/borrow for one opcode.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu
    import regfile_seq_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEFAULT
) (
    input  op_t                   i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic [DATA_WIDTH-1:0] i_imm,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_carry
);

    // One extra bit so the carry (ADD) or borrow (SUB) falls out of the MSB
    logic [DATA_WIDTH:0] w_sum;
    logic [DATA_WIDTH:0] w_diff;
    logic [3:0]          w_shamt;

    assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
    assign w_shamt = i_b[3:0];

    // Opcode decode; carry stays zero for everything but ADD/SUB
    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = w_sum[DATA_WIDTH-1:0];
                o_carry  = w_sum[DATA_WIDTH];
            end
            OP_SUB: begin
                o_result = w_diff[DATA_WIDTH-1:0];
                o_carry  = w_diff[DATA_WIDTH];
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SHL:  o_result = i_a << w_shamt;
            OP_SHR:  o_result = i_a >> w_shamt;
            OP_LDI:  o_result = i_imm;
            default: o_result = '0;
        endcase
    end

endmodule : seq_alu
`default_nettype wire

// File: rtl/regfile_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : regfile_alu_sequencer
// Brief    : Sole driver of the 64x16 register file port set. Accepts one
//            register-to-register operation, reads both operands, computes
//            the ALU result and writes it back (IDLE-READ-EXEC-WRITE).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_alu_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH_DEFAULT
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic [2:0]            ReqOp,
    input  logic [ADDR_WIDTH-1:0] ReqDest,
    input  logic [ADDR_WIDTH-1:0] ReqSrcA,
    input  logic [ADDR_WIDTH-1:0] ReqSrcB,
    input  logic [DATA_WIDTH-1:0] ReqImm,
    output logic [ADDR_WIDTH-1:0] AddressA,
    output logic [ADDR_WIDTH-1:0] AddressB,
    input  logic [DATA_WIDTH-1:0] ReadDataA,
    input  logic [DATA_WIDTH-1:0] ReadDataB,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  WriteEnable,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  FlagZero,
    output logic                  FlagCarry
);

    state_t                r_state;
    state_t                w_nextState;
    logic                  w_accept;

    op_t                   r_op;
    logic [ADDR_WIDTH-1:0] r_dest;
    logic [ADDR_WIDTH-1:0] r_srcA;
    logic [ADDR_WIDTH-1:0] r_srcB;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [DATA_WIDTH-1:0] r_operandA;
    logic [DATA_WIDTH-1:0] r_operandB;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_flagZero;
    logic                  r_flagCarry;

    logic [DATA_WIDTH-1:0] w_aluResult;
    logic                  w_aluCarry;

    seq_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .i_op     (r_op),
        .i_a      (r_operandA),
        .i_b      (r_operandB),
        .i_imm    (r_imm),
        .o_result (w_aluResult),
        .o_carry  (w_aluCarry)
    );

    // State register; reset wins over any request in the same cycle
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and port-side decode. WriteEnable/Done are masked by Reset so
    // a reset landing in WRITE never commits to the register file.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        ReqReady    = 1'b0;
        Busy        = 1'b1;
        WriteEnable = 1'b0;
        Done        = 1'b0;
        AddressA    = r_srcA;
        case (r_state)
            IDLE: begin
                Busy     = 1'b0;
                ReqReady = ~Reset;
                w_accept = ReqValid & ~Reset;
                if (w_accept) begin
                    w_nextState = READ;
                end
            end
            READ:  w_nextState = EXEC;
            EXEC:  w_nextState = WRITE;
            WRITE: begin
                AddressA    = r_dest;
                WriteEnable = ~Reset;
                Done        = ~Reset;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Request capture, operand latch in READ, result/flag update in EXEC
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_op        <= OP_ADD;
            r_dest      <= '0;
            r_srcA      <= '0;
            r_srcB      <= '0;
            r_imm       <= '0;
            r_operandA  <= '0;
            r_operandB  <= '0;
            r_result    <= '0;
            r_flagZero  <= 1'b0;
            r_flagCarry <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op   <= op_t'(ReqOp);
                r_dest <= ReqDest;
                r_srcA <= ReqSrcA;
                r_srcB <= ReqSrcB;
                r_imm  <= ReqImm;
            end
            if (r_state == READ) begin
                r_operandA <= ReadDataA;
                r_operandB <= ReadDataB;
            end
            if (r_state == EXEC) begin
                r_result    <= w_aluResult;
                r_flagZero  <= (w_aluResult == '0);
                r_flagCarry <= w_aluCarry;
            end
        end
    end

    assign AddressB  = r_srcB;
    assign WriteData = r_result;
    assign Result    = r_result;
    assign FlagZero  = r_flagZero;
    assign FlagCarry = r_flagCarry;

endmodule : regfile_alu_sequencer
`default_nettype wire

// File: tb/tb_regfile_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_alu_sequencer
// Brief    : Self-checking bench for regfile_alu_sequencer with a behavioural
//            register file and an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_alu_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic [2:0]  ReqOp = '0;
    logic [5:0]  ReqDest = '0;
    logic [5:0]  ReqSrcA = '0;
    logic [5:0]  ReqSrcB = '0;
    logic [15:0] ReqImm = '0;
    logic [5:0]  AddressA;
    logic [5:0]  AddressB;
    logic [15:0] ReadDataA;
    logic [15:0] ReadDataB;
    logic [15:0] WriteData;
    logic        WriteEnable;
    logic        Busy;
    logic        Done;
    logic [15:0] Result;
    logic        FlagZero;
    logic        FlagCarry;

    int checks = 0;
    int errors = 0;

    // Register file seen by the DUT
    logic [15:0] rf [64] = '{default: 16'h0000};
    // Reference copy of the architectural register contents
    logic [15:0] mdl [64] = '{default: 16'h0000};

    logic [15:0] lastWd;
    int          cyc = 0;
    int          acceptCyc [$];

    regfile_alu_sequencer dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .ReqValid    (ReqValid),
        .ReqReady    (ReqReady),
        .ReqOp       (ReqOp),
        .ReqDest     (ReqDest),
        .ReqSrcA     (ReqSrcA),
        .ReqSrcB     (ReqSrcB),
        .ReqImm      (ReqImm),
        .AddressA    (AddressA),
        .AddressB    (AddressB),
        .ReadDataA   (ReadDataA),
        .ReadDataB   (ReadDataB),
        .WriteData   (WriteData),
        .WriteEnable (WriteEnable),
        .Busy        (Busy),
        .Done        (Done),
        .Result      (Result),
        .FlagZero    (FlagZero),
        .FlagCarry   (FlagCarry)
    );

    always #5 Clock = ~Clock;

    assign ReadDataA = rf[AddressA];
    assign ReadDataB = rf[AddressB];

    always @(posedge Clock) begin
        if (WriteEnable) rf[AddressA] <= WriteData;
    end

    // Log the cycle number of every handshake
    always @(posedge Clock) begin
        cyc <= cyc + 1;
        if (ReqValid && ReqReady) acceptCyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // {carry, result} computed straight from the opcode definitions
    function automatic logic [16:0] refCalc(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic [15:0] imm);
        int unsigned ua = a;
        int unsigned ub = b;
        int unsigned sh = b % 16;
        case (op)
            3'd0: return 17'(ua + ub);
            3'd1: return {(ua < ub), 16'(ua - ub)};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, 16'(ua << sh)};
            3'd6: return {1'b0, 16'(ua >> sh)};
            default: return {1'b0, imm};
        endcase
    endfunction

    // Issue one operation and follow it through all four phases
    task automatic doOp(input logic [2:0] op, input logic [5:0] d, input logic [5:0] a,
                        input logic [5:0] b, input logic [15:0] imm,
                        input bit hold, input bit rstInExec);
        int n = 0;
        logic [16:0] exp;
        while (ReqReady !== 1'b1 && n < 20) begin
            @(negedge Clock);
            n++;
        end
        check("ready_before_req", 32'(ReqReady), 32'd1);
        if (ReqReady !== 1'b1) return;
        exp = refCalc(op, mdl[a], mdl[b], imm);
        ReqValid = 1'b1;
        ReqOp = op; ReqDest = d; ReqSrcA = a; ReqSrcB = b; ReqImm = imm;
        @(negedge Clock);  // READ
        if (!hold) ReqValid = 1'b0;
        check("read_busy_ready", {30'd0, Busy, ReqReady}, {30'd0, 2'b10});
        check("read_addrA", 32'(AddressA), 32'(a));
        check("read_addrB", 32'(AddressB), 32'(b));
        check("read_we_done", {30'd0, WriteEnable, Done}, 32'd0);
        @(negedge Clock);  // EXEC
        check("exec_busy_ready_we", {29'd0, Busy, ReqReady, WriteEnable}, {29'd0, 3'b100});
        if (rstInExec) begin
            Reset = 1'b1;
            @(negedge Clock);
            Reset = 1'b0;
            #1;
            check("rst_we_done_busy", {29'd0, WriteEnable, Done, Busy}, 32'd0);
            check("rst_result_flags", {14'd0, FlagZero, FlagCarry, Result}, 32'd0);
            check("rst_addr_wd", {4'd0, AddressA, AddressB, WriteData}, 32'd0);
            check("rst_ready", 32'(ReqReady), 32'd1);
            return;
        end
        @(negedge Clock);  // WRITE
        lastWd = WriteData;
        check("wr_we_done", {30'd0, WriteEnable, Done}, {30'd0, 2'b11});
        check("wr_addrA", 32'(AddressA), 32'(d));
        check("wr_data", 32'(WriteData), 32'(exp[15:0]));
        check("wr_result", 32'(Result), 32'(exp[15:0]));
        check("wr_flags", {30'd0, FlagZero, FlagCarry}, {30'd0, (exp[15:0] == 16'd0), exp[16]});
        mdl[d] = exp[15:0];
        @(negedge Clock);  // back to IDLE
        check("idle_ctrl", {28'd0, Done, WriteEnable, Busy, ReqReady}, {28'd0, 4'b0001});
        check("idle_hold_result", 32'(Result), 32'(exp[15:0]));
        check("idle_addrA", 32'(AddressA), 32'(a));
    endtask

    initial begin
        int n0;
        int gap1;
        int gap2;
        logic [16:0] fl;

        // Reset held two cycles
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rst_outputs", {3'd0, WriteEnable, Done, Busy, FlagZero, FlagCarry, AddressA, AddressB, 12'd0}, 32'd0);
        check("rst_data", {WriteData, Result}, 32'd0);
        Reset = 1'b0;
        #1;
        check("rst_release_ready", 32'(ReqReady), 32'd1);

        // Directed sequence
        doOp(3'd7, 6'd11, 6'd0, 6'd0, 16'h1FF4, 1'b0, 1'b0);
        doOp(3'd7, 6'd9,  6'd0, 6'd0, 16'h1234, 1'b0, 1'b0);
        doOp(3'd0, 6'd3,  6'd11, 6'd9, 16'h0000, 1'b0, 1'b0);
        check("add_r3_const", 32'(lastWd), 32'h3228);
        check("add_r3_flags", {30'd0, FlagZero, FlagCarry}, 32'd0);

        doOp(3'd7, 6'd1, 6'd0, 6'd0, 16'hFFFF, 1'b0, 1'b0);
        doOp(3'd7, 6'd2, 6'd0, 6'd0, 16'h0001, 1'b0, 1'b0);
        doOp(3'd0, 6'd4, 6'd1, 6'd2, 16'h0000, 1'b0, 1'b0);
        check("add_wrap_const", {14'd0, FlagZero, FlagCarry, lastWd}, {14'd0, 2'b11, 16'h0000});
        doOp(3'd1, 6'd5, 6'd9, 6'd11, 16'h0000, 1'b0, 1'b0);
        check("sub_borrow_const", {15'd0, FlagCarry, lastWd}, {15'd0, 1'b1, 16'hF240});

        doOp(3'd0, 6'd11, 6'd11, 6'd11, 16'h0000, 1'b0, 1'b0);
        check("add_self_const", 32'(lastWd), 32'h3FE8);
        doOp(3'd3, 6'd6, 6'd11, 6'd11, 16'h0000, 1'b0, 1'b0);
        check("or_self_const", 32'(lastWd), 32'h3FE8);

        // Back-to-back with ReqValid held high
        n0 = acceptCyc.size();
        doOp(3'd0, 6'd12, 6'd3, 6'd9, 16'h0000, 1'b1, 1'b0);
        doOp(3'd4, 6'd13, 6'd12, 6'd5, 16'h0000, 1'b1, 1'b0);
        doOp(3'd5, 6'd14, 6'd13, 6'd2, 16'h0000, 1'b1, 1'b0);
        ReqValid = 1'b0;
        repeat (3) @(negedge Clock);
        check("hold_accept_count", 32'(acceptCyc.size() - n0), 32'd3);
        gap1 = (acceptCyc.size() >= n0 + 3) ? acceptCyc[n0+1] - acceptCyc[n0] : -1;
        gap2 = (acceptCyc.size() >= n0 + 3) ? acceptCyc[n0+2] - acceptCyc[n0+1] : -1;
        check("hold_gap1", 32'(gap1), 32'd4);
        check("hold_gap2", 32'(gap2), 32'd4);

        // Reset during EXEC leaves R7 untouched
        doOp(3'd7, 6'd7, 6'd0, 6'd0, 16'h5A5A, 1'b0, 1'b0);
        doOp(3'd0, 6'd7, 6'd1, 6'd2, 16'h0000, 1'b0, 1'b1);
        doOp(3'd3, 6'd8, 6'd7, 6'd7, 16'h0000, 1'b0, 1'b0);
        check("rst_exec_r7_kept", 32'(lastWd), 32'h5A5A);

        // Directed shift checks, then random ops against the model
        doOp(3'd7, 6'd20, 6'd0, 6'd0, 16'h000F, 1'b0, 1'b0);
        doOp(3'd5, 6'd21, 6'd5, 6'd20, 16'h0000, 1'b0, 1'b0);
        fl = refCalc(3'd5, 16'hF240, 16'h000F, 16'h0);
        check("shl15_const", 32'(lastWd), 32'(fl[15:0]));
        doOp(3'd6, 6'd22, 6'd5, 6'd20, 16'h0000, 1'b0, 1'b0);
        check("shr15_const", 32'(lastWd), 32'h0001);

        for (int i = 0; i < 60; i++) begin
            doOp(3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                 6'($urandom_range(0, 63)), 16'($urandom), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regfile_alu_sequencer
`default_nettype wire
